// File: rtl/ma_stage_if.sv
// -----------------------------------------------------------------------------
// ma_stage_if -- data-memory bus between the MA pipeline stage and the memory.
//
// Signals:
//   dmem_req    request, held high until dmem_ack
//   dmem_we     1 = store, 0 = load
//   dmem_adr    word address (byte address [31:2])
//   dmem_be     byte enables
//   dmem_wdata  store data, already replicated onto the enabled lanes
//   dmem_rdata  load data, valid in the ack cycle
//   dmem_ack    access complete
//
// Modports:
//   master  the MA stage (drives the request side)
//   slave   the memory (drives rdata/ack)
// -----------------------------------------------------------------------------
interface ma_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/ma_stage.sv
// -----------------------------------------------------------------------------
// ma_stage -- memory-access pipeline stage.
//
// Issues loads/stores on the data-memory bus, waits for the ack (stalling the
// pipeline meanwhile), formats load data and updates the WB pipeline
// registers.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_ld_ma/st_ma    load / store present in MA
//   rd_adr_ma          destination register
//   wbk_rd_reg_ma      writeback enable
//   rd_data_ma         ALU result, also the ld/st byte address
//   st_data_ma         store data
//   ldst_code_ma       funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   stall_in           downstream/global stall
//   rst_pipe           synchronous pipeline flush
//   dmem               data-memory bus (master side)
//   rd_adr_wb, wbk_data_wb, wbk_rd_reg_wb   WB pipeline registers
//   wbk_data_wb2       wbk_data_wb delayed one advance (EX forwarding)
//   ma_stall           MA is waiting on memory, upstream must hold
//   misalign_ma        one-cycle pulse for a misaligned ld/st
// -----------------------------------------------------------------------------
module ma_stage (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_ld_ma,
    input  logic              cmd_st_ma,
    input  logic [4:0]        rd_adr_ma,
    input  logic              wbk_rd_reg_ma,
    input  logic [31:0]       rd_data_ma,
    input  logic [31:0]       st_data_ma,
    input  logic [2:0]        ldst_code_ma,
    input  logic              stall_in,
    input  logic              rst_pipe,
    ma_stage_if.master        dmem,
    output logic [4:0]        rd_adr_wb,
    output logic [31:0]       wbk_data_wb,
    output logic              wbk_rd_reg_wb,
    output logic [31:0]       wbk_data_wb2,
    output logic              ma_stall,
    output logic              misalign_ma
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_rd_adr_wb;
    logic [31:0] r_wbk_data_wb;
    logic        r_wbk_rd_reg_wb;
    logic [31:0] r_wbk_data_wb2;
    logic [31:0] r_hold;
    // Set when the access finished while stall_in held the WB update back:
    // the result then comes from r_hold and no second request is issued.
    logic        r_done;

    logic        w_ldst;
    logic        w_aligned;
    logic        w_access;
    logic        w_misaligned;
    logic        w_req_fsm;
    logic        w_req;
    logic        w_stall;
    logic        w_adv;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_raw;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;
    logic [31:0] w_result;

    assign w_ldst = cmd_ld_ma | cmd_st_ma;

    always_comb begin
        w_aligned = 1'b1;
        case (ldst_code_ma[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~rd_data_ma[0];
            default: w_aligned = (rd_data_ma[1:0] == 2'b00);
        endcase
    end

    assign w_access     = w_ldst & w_aligned & ~rst_pipe;
    assign w_misaligned = w_ldst & ~w_aligned & ~rst_pipe;

    // FSM: next state and request
    always_comb begin
        w_state_nxt = r_state;
        w_req_fsm   = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_fsm = w_access & ~stall_in & ~r_done;
                if (w_req_fsm & ~dmem.dmem_ack)
                    w_state_nxt = WAIT;
            end
            WAIT: begin
                // stall_in does not cancel an outstanding request
                w_req_fsm = ~rst_pipe;
                if (dmem.dmem_ack | rst_pipe)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else if (rst_pipe)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Outputs are forced quiet while reset is asserted.
    assign w_req   = w_req_fsm & rst_n;
    assign w_stall = w_req & ~dmem.dmem_ack;
    assign w_adv   = ~stall_in & ~w_stall & rst_n;

    // Store byte enables / lane replication; loads read the whole word
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = st_data_ma;
        if (cmd_st_ma) begin
            case (ldst_code_ma[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << rd_data_ma[1:0];
                    w_wdata = {4{st_data_ma[7:0]}};
                end
                2'b01: begin
                    w_be    = rd_data_ma[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{st_data_ma[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = st_data_ma;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = cmd_st_ma;
    assign dmem.dmem_adr   = rd_data_ma[31:2];
    assign dmem.dmem_be    = w_be;
    assign dmem.dmem_wdata = w_wdata;

    // Load formatting
    assign w_ld_raw = r_done ? r_hold : dmem.dmem_rdata;

    always_comb begin
        w_ld_byte = w_ld_raw[7:0];
        case (rd_data_ma[1:0])
            2'b00: w_ld_byte = w_ld_raw[7:0];
            2'b01: w_ld_byte = w_ld_raw[15:8];
            2'b10: w_ld_byte = w_ld_raw[23:16];
            2'b11: w_ld_byte = w_ld_raw[31:24];
            default: w_ld_byte = w_ld_raw[7:0];
        endcase
    end

    assign w_ld_half = rd_data_ma[1] ? w_ld_raw[31:16] : w_ld_raw[15:0];

    always_comb begin
        w_ld_data = w_ld_raw;
        case (ldst_code_ma)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = {24'h0, w_ld_byte};
            3'b101:  w_ld_data = {16'h0, w_ld_half};
            default: w_ld_data = w_ld_raw;
        endcase
    end

    assign w_result = (cmd_ld_ma & ~w_misaligned) ? w_ld_data : rd_data_ma;

    // Load-data hold register and completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 32'h0;
            r_done <= 1'b0;
        end else begin
            if (w_req & dmem.dmem_ack)
                r_hold <= dmem.dmem_rdata;
            if (rst_pipe)
                r_done <= 1'b0;
            else if (w_adv)
                r_done <= 1'b0;
            else if (w_req & dmem.dmem_ack)
                r_done <= 1'b1;
        end
    end

    // WB pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_adr_wb     <= 5'h0;
            r_wbk_data_wb   <= 32'h0;
            r_wbk_rd_reg_wb <= 1'b0;
            r_wbk_data_wb2  <= 32'h0;
        end else if (rst_pipe) begin
            r_rd_adr_wb     <= 5'h0;
            r_wbk_data_wb   <= 32'h0;
            r_wbk_rd_reg_wb <= 1'b0;
            r_wbk_data_wb2  <= 32'h0;
        end else if (w_adv) begin
            r_rd_adr_wb     <= rd_adr_ma;
            r_wbk_data_wb   <= w_result;
            r_wbk_rd_reg_wb <= wbk_rd_reg_ma & ~w_misaligned;
            r_wbk_data_wb2  <= r_wbk_data_wb;
        end
    end

    assign rd_adr_wb     = r_rd_adr_wb;
    assign wbk_data_wb   = r_wbk_data_wb;
    assign wbk_rd_reg_wb = r_wbk_rd_reg_wb;
    assign wbk_data_wb2  = r_wbk_data_wb2;
    assign ma_stall      = w_stall;
    // Inputs are held while not advancing, so gating with w_adv gives a
    // single pulse per misaligned instruction.
    assign misalign_ma   = w_misaligned & w_adv;

endmodule

// File: tb/tb_ma_stage.sv
// -----------------------------------------------------------------------------
// tb_ma_stage -- scoreboard bench for ma_stage.
// The driver pushes expected bus requests and WB results into queues; a memory
// responder and a WB monitor pop and compare independently.
// -----------------------------------------------------------------------------
module tb_ma_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma, stall_in, rst_pipe;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma, st_data_ma;
    logic [2:0]  ldst_code_ma;
    logic [4:0]  rd_adr_wb;
    logic [31:0] wbk_data_wb, wbk_data_wb2;
    logic        wbk_rd_reg_wb, ma_stall, misalign_ma;

    ma_stage_if bus();

    ma_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_ld_ma     (cmd_ld_ma),
        .cmd_st_ma     (cmd_st_ma),
        .rd_adr_ma     (rd_adr_ma),
        .wbk_rd_reg_ma (wbk_rd_reg_ma),
        .rd_data_ma    (rd_data_ma),
        .st_data_ma    (st_data_ma),
        .ldst_code_ma  (ldst_code_ma),
        .stall_in      (stall_in),
        .rst_pipe      (rst_pipe),
        .dmem          (bus),
        .rd_adr_wb     (rd_adr_wb),
        .wbk_data_wb   (wbk_data_wb),
        .wbk_rd_reg_wb (wbk_rd_reg_wb),
        .wbk_data_wb2  (wbk_data_wb2),
        .ma_stall      (ma_stall),
        .misalign_ma   (misalign_ma)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] adr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } mem_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
        int          stalls;
        int          mis;
    } wb_t;

    mem_t mem_q[$];
    wb_t  wb_q[$];
    int   n_tot = 0;
    int   n_pass = 0;
    bit   tracked = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic nop();
        cmd_ld_ma = 0; cmd_st_ma = 0; rd_adr_ma = 0; wbk_rd_reg_ma = 0;
        rd_data_ma = 0; st_data_ma = 0; ldst_code_ma = 0;
    endtask

    task automatic expect_mem(input logic [29:0] adr, input logic we, input logic [3:0] be,
                              input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
        mem_t m;
        m.adr = adr; m.we = we; m.be = be; m.wdata = wdata; m.delay = delay; m.rdata = rdata;
        mem_q.push_back(m);
    endtask

    // Present one instruction, apply stall_in over cycles [s_at, s_at+s_len),
    // hold until accepted, then return to nop.
    task automatic issue(input logic ld, input logic st, input logic [2:0] code,
                         input logic [31:0] adr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic wen,
                         input int s_at, input int s_len,
                         input logic [31:0] e_data, input logic e_wen,
                         input int e_st, input int e_mis);
        wb_t e;
        int  k;
        bit  done;
        e.rd = rd; e.data = e_data; e.wen = e_wen; e.stalls = e_st; e.mis = e_mis;
        wb_q.push_back(e);
        cmd_ld_ma = ld; cmd_st_ma = st; ldst_code_ma = code; rd_data_ma = adr;
        st_data_ma = sd; rd_adr_ma = rd; wbk_rd_reg_ma = wen;
        tracked = 1'b1;
        k = 0; done = 1'b0;
        while (!done) begin
            stall_in = (k >= s_at) && (k < s_at + s_len);
            @(negedge clk); #2;
            if (!stall_in && !ma_stall) done = 1'b1;
            else if (k >= 50) begin chk("issue_timeout", 1, 0); done = 1'b1; end
            @(posedge clk); #1;
            k++;
        end
        nop();
        stall_in = 1'b0;
        tracked = 1'b0;
    endtask

    // Memory responder: checks each request against the expected queue,
    // checks it stays stable while waiting, and acks after the set delay.
    initial begin
        mem_t cur;
        bit   busy;
        int   cnt;
        busy = 1'b0; cnt = 0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'hDEAD_0000;
        cur.adr = 0; cur.we = 0; cur.be = 0; cur.wdata = 0; cur.delay = 0; cur.rdata = 0;
        forever begin
            @(negedge clk);
            if (!bus.dmem_req) begin
                busy = 1'b0;
                bus.dmem_ack = 1'b0;
            end else begin
                if (!busy) begin
                    if (mem_q.size() == 0) begin
                        chk("unexpected_req", 1, 0);
                        cur.adr = bus.dmem_adr; cur.we = bus.dmem_we; cur.be = bus.dmem_be;
                        cur.wdata = bus.dmem_wdata; cur.delay = 0; cur.rdata = 0;
                    end else begin
                        cur = mem_q.pop_front();
                        chk("req_adr", {2'b0, bus.dmem_adr}, {2'b0, cur.adr});
                        chk("req_we", {31'b0, bus.dmem_we}, {31'b0, cur.we});
                        chk("req_be", {28'b0, bus.dmem_be}, {28'b0, cur.be});
                        if (cur.we) chk("req_wdata", bus.dmem_wdata, cur.wdata);
                        else cur.wdata = bus.dmem_wdata;
                    end
                    busy = 1'b1; cnt = 0;
                end else begin
                    chk("req_stable",
                        {31'b0, (bus.dmem_adr == cur.adr && bus.dmem_we == cur.we &&
                                 bus.dmem_be == cur.be && bus.dmem_wdata == cur.wdata)}, 1);
                end
                if (cnt == cur.delay) begin
                    bus.dmem_ack = 1'b1; bus.dmem_rdata = cur.rdata; busy = 1'b0;
                end else begin
                    bus.dmem_ack = 1'b0;
                end
                cnt++;
            end
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'hDEAD_0000;
        end
    end

    // WB monitor: models the WB/WB2 register chain and checks each tracked
    // instruction when it advances.
    initial begin
        wb_t         e;
        logic [31:0] m_cur, m_prev;
        int          st_cnt, mis_cnt;
        bit          adv, trk, flush;
        m_cur = 0; m_prev = 0; st_cnt = 0; mis_cnt = 0;
        forever begin
            @(negedge clk); #2;
            flush = !rst_n || rst_pipe;
            adv   = rst_n && !rst_pipe && !stall_in && !ma_stall;
            trk   = tracked;
            if (trk) begin
                st_cnt  += int'(ma_stall);
                mis_cnt += int'(misalign_ma);
            end
            @(posedge clk); #1;
            if (flush || !rst_n) begin
                m_cur = 0; m_prev = 0; st_cnt = 0; mis_cnt = 0;
            end else if (adv) begin
                m_prev = m_cur;
                if (trk && wb_q.size() > 0) begin
                    e = wb_q.pop_front();
                    m_cur = e.data;
                    chk("wb_rd", {27'b0, rd_adr_wb}, {27'b0, e.rd});
                    chk("wb_data", wbk_data_wb, e.data);
                    chk("wb_wen", {31'b0, wbk_rd_reg_wb}, {31'b0, e.wen});
                    chk("wb_data2", wbk_data_wb2, m_prev);
                    chk("ma_stall_cycles", st_cnt, e.stalls);
                    chk("misalign_pulses", mis_cnt, e.mis);
                    st_cnt = 0; mis_cnt = 0;
                end else begin
                    m_cur = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop();
        stall_in = 0; rst_pipe = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, bus.dmem_req}, 0);
        chk("rst_stall", {31'b0, ma_stall}, 0);
        chk("rst_misalign", {31'b0, misalign_ma}, 0);
        chk("rst_wb_data", wbk_data_wb, 0);
        chk("rst_wb_data2", wbk_data_wb2, 0);
        chk("rst_wb_wen", {31'b0, wbk_rd_reg_wb}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // ALU pass-through, plain and with an upstream stall
        issue(0, 0, 3'b000, 32'hDEAD_BEEF, 0, 5'd3, 1, 0, 0, 32'hDEAD_BEEF, 1, 0, 0);
        issue(0, 0, 3'b000, 32'h0000_0011, 0, 5'd4, 1, 0, 2, 32'h0000_0011, 1, 0, 0);
        // lb 0x103, zero-wait
        expect_mem(30'h40, 0, 4'b1111, 0, 0, 32'h80FF_1234);
        issue(1, 0, 3'b000, 32'h103, 0, 5'd5, 1, 0, 0, 32'hFFFF_FF80, 1, 0, 0);
        // sh 0x202, three wait cycles
        expect_mem(30'h80, 1, 4'b1100, 32'hABCD_ABCD, 3, 0);
        issue(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd0, 0, 0, 0, 32'h202, 0, 3, 0);
        // lw 0x101 misaligned
        issue(1, 0, 3'b010, 32'h101, 0, 5'd6, 1, 0, 0, 32'h101, 0, 0, 1);
        // lhu 0x2, ack on 2nd WAIT cycle under a 4-cycle stall_in
        expect_mem(30'h0, 0, 4'b1111, 0, 2, 32'h8001_0000);
        issue(1, 0, 3'b101, 32'h2, 0, 5'd7, 1, 1, 4, 32'h0000_8001, 1, 2, 0);
        // sb 0x7
        expect_mem(30'h1, 1, 4'b1000, 32'h7878_7878, 1, 0);
        issue(0, 1, 3'b000, 32'h7, 32'h1234_5678, 5'd0, 0, 0, 0, 32'h7, 0, 1, 0);
        // sw 0x10
        expect_mem(30'h4, 1, 4'b1111, 32'hCAFE_F00D, 0, 0);
        issue(0, 1, 3'b010, 32'h10, 32'hCAFE_F00D, 5'd0, 0, 0, 0, 32'h10, 0, 0, 0);
        // lh 0x6 (upper half, positive), lh 0x4 (lower half, negative)
        expect_mem(30'h1, 0, 4'b1111, 0, 1, 32'h7FFF_8001);
        issue(1, 0, 3'b001, 32'h6, 0, 5'd8, 1, 0, 0, 32'h0000_7FFF, 1, 1, 0);
        expect_mem(30'h1, 0, 4'b1111, 0, 0, 32'h1234_8001);
        issue(1, 0, 3'b001, 32'h4, 0, 5'd9, 1, 0, 0, 32'hFFFF_8001, 1, 0, 0);
        // lbu 0x1, lb 0x2
        expect_mem(30'h0, 0, 4'b1111, 0, 0, 32'h0000_F000);
        issue(1, 0, 3'b100, 32'h1, 0, 5'd10, 1, 0, 0, 32'h0000_00F0, 1, 0, 0);
        expect_mem(30'h0, 0, 4'b1111, 0, 0, 32'h00AB_0000);
        issue(1, 0, 3'b000, 32'h2, 0, 5'd11, 1, 0, 0, 32'hFFFF_FFAB, 1, 0, 0);
        // lhu 0x3 and sh 0x1 misaligned
        issue(1, 0, 3'b101, 32'h3, 0, 5'd12, 1, 0, 0, 32'h3, 0, 0, 1);
        issue(0, 1, 3'b001, 32'h1, 32'h5555, 5'd0, 0, 0, 0, 32'h1, 0, 0, 1);
        // lw 0x8
        expect_mem(30'h2, 0, 4'b1111, 0, 0, 32'h0123_4567);
        issue(1, 0, 3'b010, 32'h8, 0, 5'd13, 1, 0, 0, 32'h0123_4567, 1, 0, 0);

        // rst_pipe while waiting on memory
        expect_mem(30'h8, 0, 4'b1111, 0, 10, 0);
        cmd_ld_ma = 1; ldst_code_ma = 3'b010; rd_data_ma = 32'h20; rd_adr_ma = 5'd14; wbk_rd_reg_ma = 1;
        repeat (2) begin @(posedge clk); #1; end
        rst_pipe = 1;
        @(negedge clk); #2;
        chk("flush_req", {31'b0, bus.dmem_req}, 0);
        chk("flush_stall", {31'b0, ma_stall}, 0);
        @(posedge clk); #1;
        chk("flush_wb_rd", {27'b0, rd_adr_wb}, 0);
        chk("flush_wb_data", wbk_data_wb, 0);
        chk("flush_wb_wen", {31'b0, wbk_rd_reg_wb}, 0);
        chk("flush_wb_data2", wbk_data_wb2, 0);
        rst_pipe = 0;
        nop();
        @(negedge clk); #2;
        chk("flush_idle_req", {31'b0, bus.dmem_req}, 0);
        @(posedge clk); #1;
        expect_mem(30'h8, 0, 4'b1111, 0, 0, 32'h55AA_55AA);
        issue(1, 0, 3'b010, 32'h20, 0, 5'd15, 1, 0, 0, 32'h55AA_55AA, 1, 0, 0);

        // asynchronous reset while waiting on memory
        expect_mem(30'h3, 0, 4'b1111, 0, 10, 0);
        cmd_ld_ma = 1; ldst_code_ma = 3'b010; rd_data_ma = 32'hC; rd_adr_ma = 5'd16; wbk_rd_reg_ma = 1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 0;
        #1;
        chk("arst_req", {31'b0, bus.dmem_req}, 0);
        chk("arst_stall", {31'b0, ma_stall}, 0);
        chk("arst_misalign", {31'b0, misalign_ma}, 0);
        chk("arst_wb_rd", {27'b0, rd_adr_wb}, 0);
        chk("arst_wb_data", wbk_data_wb, 0);
        chk("arst_wb_wen", {31'b0, wbk_rd_reg_wb}, 0);
        chk("arst_wb_data2", wbk_data_wb2, 0);
        nop();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) begin @(posedge clk); #1; end

        chk("wb_q_drained", wb_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
